// File: rtl/chip8_sound_pkg.sv
// Shared types and constants for the CHIP-8 beep sequencer.
package chip8_sound_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    HOLD      = 2'd2,
    RAMP_DOWN = 2'd3
  } snd_state_t;

  localparam int unsigned GAIN_W             = 5;
  localparam int unsigned DEFAULT_GAIN_SHIFT = 4;

endpackage

// File: rtl/chip8_tick_div.sv
// Free-running divider producing a one-cycle tick every CLK_DIV clocks.
module chip8_tick_div #(
  parameter int unsigned CLK_DIV = 833333
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int unsigned     CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0]   LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/chip8_sound_ctrl.sv
// CHIP-8 sound timer, tone enable sequencing and click-free linear gain ramp.
module chip8_sound_ctrl
  import chip8_sound_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 833333,
  parameter int unsigned GAIN_SHIFT = DEFAULT_GAIN_SHIFT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        st_wr,
  input  logic [7:0]  st_wdata,
  output logic [7:0]  st_value,
  input  logic        sample_req,
  input  logic [15:0] sample_in,
  output logic        tone_enable,
  output logic [15:0] sample_out,
  output logic        busy
);

  localparam logic [GAIN_W-1:0] GAIN_MAX = GAIN_W'(1 << GAIN_SHIFT);

  logic              tick;
  logic [7:0]        st_q, st_d;
  snd_state_t        state_q, state_d;
  logic [GAIN_W-1:0] gain_q, gain_d, gain_up, gain_dn;
  logic [15:0]       sample_q, sample_d;
  logic signed [21:0] samp_x, gain_x, prod, prod_sh;

  chip8_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  // Write has priority over the tick so a coincident load is never decremented.
  always_comb begin
    st_d = st_q;
    if (st_wr)                  st_d = st_wdata;
    else if (tick && st_q != '0) st_d = st_q - 8'd1;
  end

  always_comb begin
    gain_up = (gain_q < GAIN_MAX) ? gain_q + GAIN_W'(1) : GAIN_MAX;
    gain_dn = (gain_q != '0)      ? gain_q - GAIN_W'(1) : '0;
    state_d = state_q;
    gain_d  = gain_q;
    case (state_q)
      IDLE: begin
        if (st_q != '0) state_d = RAMP_UP;
      end
      RAMP_UP: begin
        if (sample_req) gain_d = gain_up;
        if (st_q == '0)            state_d = RAMP_DOWN;
        else if (gain_d == GAIN_MAX) state_d = HOLD;
      end
      HOLD: begin
        if (st_q == '0) state_d = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (sample_req) gain_d = gain_dn;
        if (st_q != '0)       state_d = RAMP_UP;
        else if (gain_d == '0) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gain_d  = '0;
      end
    endcase
  end

  // Product uses the pre-update gain; the shifted value always fits 16 bits.
  always_comb begin
    samp_x   = 22'(signed'(sample_in));
    gain_x   = 22'({1'b0, gain_q});
    prod     = samp_x * gain_x;
    prod_sh  = prod >>> GAIN_SHIFT;
    sample_d = sample_q;
    if (sample_req) sample_d = (state_q == IDLE) ? '0 : prod_sh[15:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q     <= '0;
      state_q  <= IDLE;
      gain_q   <= '0;
      sample_q <= '0;
    end else begin
      st_q     <= st_d;
      state_q  <= state_d;
      gain_q   <= gain_d;
      sample_q <= sample_d;
    end
  end

  assign st_value    = st_q;
  assign sample_out  = sample_q;
  assign busy        = (state_q != IDLE);
  assign tone_enable = (state_q != IDLE);

endmodule

// File: tb/tb_chip8_sound_ctrl.sv
// Directed scoreboard bench for chip8_sound_ctrl with a fast 10-clock tick.
module tb_chip8_sound_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        st_wr = 1'b0;
  logic [7:0]  st_wdata = '0;
  logic        sample_req = 1'b0;
  logic [15:0] sample_in = '0;
  logic [7:0]  st_value;
  logic        tone_enable;
  logic [15:0] sample_out;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [15:0] exp_q[$];

  chip8_sound_ctrl #(.CLK_DIV(10), .GAIN_SHIFT(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .st_wr       (st_wr),
    .st_wdata    (st_wdata),
    .st_value    (st_value),
    .sample_req  (sample_req),
    .sample_in   (sample_in),
    .tone_enable (tone_enable),
    .sample_out  (sample_out),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic write_st(input logic [7:0] v);
    st_wr    = 1'b1;
    st_wdata = v;
    step();
    st_wr    = 1'b0;
  endtask

  function automatic logic [15:0] scaled(input logic [15:0] s, input int g);
    int p;
    p = int'($signed(s)) * g;
    p = p >>> 4;
    return p[15:0];
  endfunction

  // One request, then three idle clocks (request period of 4 clk).
  task automatic do_req(input logic [15:0] s, input int g, input string tag);
    sample_in  = s;
    sample_req = 1'b1;
    exp_q.push_back(scaled(s, g));
    step();
    sample_req = 1'b0;
    if (exp_q.size() == 0) check({tag, "_empty"}, 16'd1, 16'd0);
    else                   check(tag, sample_out, exp_q.pop_front());
    step();
    step();
    step();
  endtask

  initial begin
    #1;
    check("rst_st",   {8'h00, st_value},     16'h0000);
    check("rst_tone", {15'h0, tone_enable},  16'h0000);
    check("rst_busy", {15'h0, busy},         16'h0000);
    check("rst_out",  sample_out,            16'h0000);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc     = 0;

    // Timer countdown
    write_st(8'd3);
    check("st_load3", {8'h00, st_value}, 16'd3);
    run_to(9);  check("st_c9",  {8'h00, st_value}, 16'd3);
    run_to(10); check("st_c10", {8'h00, st_value}, 16'd2);
    run_to(20); check("st_c20", {8'h00, st_value}, 16'd1);
    run_to(30); check("st_c30", {8'h00, st_value}, 16'd0);
    run_to(45); check("st_nowrap", {8'h00, st_value}, 16'd0);
    run_to(49);
    write_st(8'd5);
    check("st_wr_tick", {8'h00, st_value}, 16'd5);
    run_to(60); check("st_c60", {8'h00, st_value}, 16'd4);
    write_st(8'd0);
    step();
    step();
    check("idle_busy0", {15'h0, busy}, 16'h0000);

    // Full ramp up, hold, negative samples, full ramp down
    write_st(8'd200);
    check("tone_load_edge", {15'h0, tone_enable}, 16'h0000);
    step();
    check("tone_rise", {15'h0, tone_enable}, 16'h0001);
    for (int g = 0; g < 16; g++) do_req(16'h7FF0, g, $sformatf("up_g%0d", g));
    check("hold_busy", {15'h0, busy}, 16'h0001);
    do_req(16'h7FF0, 16, "hold_full");
    do_req(16'h8003, 16, "hold_neg");
    write_st(8'd0);
    step();
    for (int g = 16; g > 0; g--)
      do_req((g == 8) ? 16'hFFFF : 16'h7FF0, g, $sformatf("dn_g%0d", g));
    check("dn_tone0", {15'h0, tone_enable}, 16'h0000);
    check("dn_busy0", {15'h0, busy},        16'h0000);
    do_req(16'h1234, 0, "idle_zero");

    // Stop during ramp up at gain 3
    write_st(8'd200);
    step();
    for (int g = 0; g < 3; g++) do_req(16'h7FF0, g, $sformatf("stop_up_g%0d", g));
    write_st(8'd0);
    step();
    for (int g = 3; g > 0; g--) do_req(16'h7FF0, g, $sformatf("stop_dn_g%0d", g));
    check("stop_busy0", {15'h0, busy},        16'h0000);
    check("stop_tone0", {15'h0, tone_enable}, 16'h0000);
    do_req(16'h1234, 0, "idle_zero2");

    // Reload during ramp down at gain 5
    write_st(8'd200);
    step();
    for (int g = 0; g < 16; g++) do_req(16'h7FF0, g, $sformatf("rl_up_g%0d", g));
    write_st(8'd0);
    step();
    for (int g = 16; g > 5; g--) do_req(16'h7FF0, g, $sformatf("rl_dn_g%0d", g));
    write_st(8'd10);
    check("rl_tone_a", {15'h0, tone_enable}, 16'h0001);
    step();
    for (int g = 5; g < 8; g++) begin
      do_req(16'h7FF0, g, $sformatf("rl_g%0d", g));
      check($sformatf("rl_tone_g%0d", g), {15'h0, tone_enable}, 16'h0001);
    end
    for (int g = 8; g < 16; g++) do_req(16'h7FF0, g, $sformatf("rl_up2_g%0d", g));

    // Asynchronous reset while holding
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_tone", {15'h0, tone_enable}, 16'h0000);
    check("arst_busy", {15'h0, busy},        16'h0000);
    check("arst_out",  sample_out,           16'h0000);
    check("arst_st",   {8'h00, st_value},    16'h0000);
    step();
    step();
    reset_n = 1'b1;
    cyc     = 0;
    check("rel_busy", {15'h0, busy}, 16'h0000);
    write_st(8'd3);
    run_to(9);  check("rel_c9",  {8'h00, st_value}, 16'd3);
    run_to(10); check("rel_c10", {8'h00, st_value}, 16'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
